// File: rtl/input_buffer_mc.sv
// input_buffer_mc: circular trace input buffer that replays each queued
// N-lane vector once per active filter chain, with valid/ready backpressure,
// a stored EOF bit, runtime chain-count configuration and occupancy/overflow
// status.
// Optional feature: define IB_DROP_COUNT_EN to add a saturating 16-bit
// drop_count output that counts enqueues discarded because the queue was full.
module input_buffer_mc #(
  parameter int N                = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int IB_DEPTH         = 4,
  parameter int MAX_CHAINS       = 4,
  parameter int INITIAL_FIRMWARE = 1,
  parameter int CONFIG_ID        = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enqueue,
  input  logic                            eof_in,
  input  logic                            tracing,
  input  logic [7:0]                      configId,
  input  logic [7:0]                      configData,
  input  logic [N*DATA_WIDTH-1:0]         vector_in,
  input  logic                            ready_in,
  output logic                            valid_out,
  output logic                            eof_out,
  output logic [N*DATA_WIDTH-1:0]         vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]   chainId_out,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(IB_DEPTH):0]       occupancy,
  output logic                            overflow
`ifdef IB_DROP_COUNT_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  localparam int VW = N * DATA_WIDTH;
  localparam int PW = $clog2(IB_DEPTH);
  localparam int CW = $clog2(MAX_CHAINS);

  // Reset value of the chain count, with the same clamp applied to runtime writes.
  localparam int INIT_CHAINS = (INITIAL_FIRMWARE < 1) ? 1 :
                               ((INITIAL_FIRMWARE > MAX_CHAINS) ? MAX_CHAINS : INITIAL_FIRMWARE);

  localparam logic [CW:0] INIT_CHAINS_L = (CW+1)'(INIT_CHAINS);
  localparam logic [CW:0] MAX_CHAINS_L  = (CW+1)'(MAX_CHAINS);
  localparam logic [PW:0] DEPTH_L       = (PW+1)'(IB_DEPTH);
  localparam logic [7:0]  CFG_ID_L      = 8'(CONFIG_ID);

  // Chain count clamp: zero chains is meaningless, and more than the hardware
  // supports cannot be addressed by chainId_out.
  function automatic logic [CW:0] clampChains(input logic [7:0] raw);
    logic [CW:0] res;
    res = (CW+1)'(1);
    if (raw == 8'd0) begin
      res = (CW+1)'(1);
    end else if (int'(raw) > MAX_CHAINS) begin
      res = MAX_CHAINS_L;
    end else begin
      res = raw[CW:0];
    end
    return res;
  endfunction

  // Storage: each entry carries its EOF bit in the MSB above the vector.
  logic [VW:0]   mem_q [IB_DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW:0]   occ_q, occ_d;
  logic          wrSeen_q;

  logic [CW:0]   numChains_q, numChains_d;
  logic [CW:0]   curChains_q, curChains_d;

  logic          outValid_q, outValid_d;
  logic          outEof_q, outEof_d;
  logic [VW-1:0] outVec_q, outVec_d;
  logic [CW-1:0] outChain_q, outChain_d;

  logic          overflow_q, overflow_d;

  logic          isFull;
  logic          accept;
  logic          drop;
  logic          beatAccept;
  logic          lastBeat;
  logic          pop;
  logic [PW:0]   visibleCnt;
  logic [PW-1:0] rdPtrNext;
  logic [VW:0]   headEntry;
  logic [VW:0]   nextEntry;

  // Handshake decode; full comes from the registered occupancy, so a pop in
  // the same cycle never makes room for a write.
  always_comb begin
    isFull     = (occ_q == DEPTH_L);
    accept     = enqueue & tracing & ~isFull;
    drop       = enqueue & tracing & isFull;
    beatAccept = outValid_q & ready_in;
    lastBeat   = ({1'b0, outChain_q} == (curChains_q - 1'b1));
    pop        = beatAccept & lastBeat;
    rdPtrNext  = rdPtr_q + 1'b1;
    headEntry  = mem_q[rdPtr_q];
    nextEntry  = mem_q[rdPtrNext];
    // An entry written on the last edge is hidden from the read side for one
    // cycle; this gives the two-edge write-to-output latency with no bypass.
    visibleCnt = occ_q - {{PW{1'b0}}, wrSeen_q};
  end

  // Queue storage is written only on accept; reset discards entries by
  // clearing the pointers, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wrPtr_q] <= {eof_in, vector_in};
    end
  end

  // Write pointer and occupancy bookkeeping.
  always_comb begin
    wrPtr_d = wrPtr_q;
    occ_d   = occ_q;
    if (accept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (accept && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Output register: loads a fresh head when idle, steps the chain index on
  // each accepted beat, and retires the entry after its final chain.
  always_comb begin
    outValid_d  = outValid_q;
    outEof_d    = outEof_q;
    outVec_d    = outVec_q;
    outChain_d  = outChain_q;
    curChains_d = curChains_q;
    rdPtr_d     = rdPtr_q;
    if (!outValid_q) begin
      if (visibleCnt != '0) begin
        outValid_d  = 1'b1;
        outEof_d    = headEntry[VW];
        outVec_d    = headEntry[VW-1:0];
        outChain_d  = '0;
        curChains_d = numChains_q;
      end
    end else if (beatAccept) begin
      if (!lastBeat) begin
        outChain_d = outChain_q + 1'b1;
      end else begin
        rdPtr_d = rdPtrNext;
        if (visibleCnt > (PW+1)'(1)) begin
          outEof_d    = nextEntry[VW];
          outVec_d    = nextEntry[VW-1:0];
          outChain_d  = '0;
          curChains_d = numChains_q;
        end else begin
          outValid_d = 1'b0;
        end
      end
    end
  end

  // Chain-count configuration is only accepted outside tracing; the sticky
  // overflow flag latches any enqueue that found the queue full.
  always_comb begin
    numChains_d = numChains_q;
    overflow_d  = overflow_q;
    if (!tracing && (configId == CFG_ID_L)) begin
      numChains_d = clampChains(configData);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Queue pointers, occupancy and the write-visibility delay flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      occ_q    <= '0;
      wrSeen_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      occ_q    <= occ_d;
      wrSeen_q <= accept;
    end
  end

  // Output beat register and the chain count latched for the entry in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outEof_q    <= 1'b0;
      outVec_q    <= '0;
      outChain_q  <= '0;
      curChains_q <= INIT_CHAINS_L;
    end else begin
      outValid_q  <= outValid_d;
      outEof_q    <= outEof_d;
      outVec_q    <= outVec_d;
      outChain_q  <= outChain_d;
      curChains_q <= curChains_d;
    end
  end

  // Configuration and sticky status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      numChains_q <= INIT_CHAINS_L;
      overflow_q  <= 1'b0;
    end else begin
      numChains_q <= numChains_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef IB_DROP_COUNT_EN
  logic [15:0] dropCnt_q, dropCnt_d;

  // Saturating count of enqueues discarded while full.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (drop && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_count = dropCnt_q;
`endif

  assign valid_out   = outValid_q;
  assign eof_out     = outEof_q;
  assign vector_out  = outVec_q;
  assign chainId_out = outChain_q;
  assign full        = isFull;
  assign empty       = (occ_q == '0);
  assign occupancy   = occ_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_input_buffer_mc.sv
// tb_input_buffer_mc: randomized and directed bench for input_buffer_mc,
// checked against a queue-based model of the replay/occupancy rules.
module tb_input_buffer_mc;

  localparam int N      = 8;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int MAXC   = 4;
  localparam int INITFW = 1;
  localparam int CFGID  = 0;
  localparam int VW     = N * DW;
  localparam int CW     = $clog2(MAXC);
  localparam int PW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enqueue;
  logic              eof_in;
  logic              tracing;
  logic [7:0]        configId;
  logic [7:0]        configData;
  logic [VW-1:0]     vector_in;
  logic              ready_in;
  logic              valid_out;
  logic              eof_out;
  logic [VW-1:0]     vector_out;
  logic [CW-1:0]     chainId_out;
  logic              full;
  logic              empty;
  logic [PW:0]       occupancy;
  logic              overflow;
`ifdef IB_DROP_COUNT_EN
  logic [15:0]       dropCount;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: queued entries in arrival order, the chain index of the
  // head entry's current beat, and the status the block should report.
  logic [VW-1:0] mVec[$];
  logic          mEof[$];
  int            mChain;
  int            mChains;
  logic          mOverflow;
  int            mDrops;

  input_buffer_mc #(
    .N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH), .MAX_CHAINS(MAXC),
    .INITIAL_FIRMWARE(INITFW), .CONFIG_ID(CFGID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enqueue(enqueue), .eof_in(eof_in),
    .tracing(tracing), .configId(configId), .configData(configData),
    .vector_in(vector_in), .ready_in(ready_in), .valid_out(valid_out),
    .eof_out(eof_out), .vector_out(vector_out), .chainId_out(chainId_out),
    .full(full), .empty(empty), .occupancy(occupancy), .overflow(overflow)
`ifdef IB_DROP_COUNT_EN
    , .drop_count(dropCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic int clampModel(input int v);
    if (v < 1) return 1;
    if (v > MAXC) return MAXC;
    return v;
  endfunction

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int l = 0; l < N; l++) v[l*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                             input logic [VW-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Status every cycle, plus beat contents whenever a beat is presented.
  task automatic checkState();
    checkOutput("occupancy", VW'(occupancy), VW'(mVec.size()));
    checkOutput("full", VW'(full), VW'(mVec.size() == DEPTH));
    checkOutput("empty", VW'(empty), VW'(mVec.size() == 0));
    checkOutput("overflow", VW'(overflow), VW'(mOverflow));
`ifdef IB_DROP_COUNT_EN
    checkOutput("dropCount", VW'(dropCount), VW'(mDrops));
`endif
    if (valid_out) begin
      if (mVec.size() == 0) begin
        checkOutput("spuriousValid", VW'(valid_out), '0);
      end else begin
        checkOutput("beatVector", vector_out, mVec[0]);
        checkOutput("beatEof", VW'(eof_out), VW'(mEof[0]));
        checkOutput("beatChain", VW'(chainId_out), VW'(mChain));
      end
    end
  endtask

  // One clock: drive inputs, advance the model by the rules, check after the edge.
  task automatic applyStimulus(input logic enq, input logic eofBit,
                               input logic [VW-1:0] vec, input logic rdy,
                               input logic trc, input logic [7:0] cfgId,
                               input logic [7:0] cfgData);
    logic beatTaken;
    logic acceptOk;
    enqueue    = enq;
    eof_in     = eofBit;
    vector_in  = vec;
    ready_in   = rdy;
    tracing    = trc;
    configId   = cfgId;
    configData = cfgData;
    beatTaken  = valid_out && rdy;
    acceptOk   = enq && trc && (mVec.size() < DEPTH);
    @(posedge clk);
    if (beatTaken && mVec.size() > 0) begin
      mChain++;
      if (mChain >= mChains) begin
        void'(mVec.pop_front());
        void'(mEof.pop_front());
        mChain = 0;
      end
    end
    if (acceptOk) begin
      mVec.push_back(vec);
      mEof.push_back(eofBit);
    end
    if (enq && trc && !acceptOk) begin
      mOverflow = 1'b1;
      if (mDrops < 65535) mDrops++;
    end
    if (!trc && cfgId == 8'(CFGID)) mChains = clampModel(int'(cfgData));
    @(negedge clk);
    checkState();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, '0, rdy, 1'b1, 8'hFF, 8'h00);
  endtask

  task automatic writeVec(input logic [VW-1:0] vec, input logic eofBit, input logic rdy);
    applyStimulus(1'b1, eofBit, vec, rdy, 1'b1, 8'hFF, 8'h00);
  endtask

  task automatic configure(input logic [7:0] data);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'(CFGID), data);
  endtask

  task automatic drainAll(input int budget);
    int cyc = 0;
    while ((mVec.size() != 0 || valid_out) && cyc < budget) begin
      idle(1'b1);
      cyc++;
    end
    checkOutput("drainDone", VW'(mVec.size() == 0 && !valid_out), VW'(1));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic applyReset();
    enqueue    = 1'b0;
    eof_in     = 1'b0;
    vector_in  = '0;
    ready_in   = 1'b0;
    tracing    = 1'b1;
    configId   = 8'hFF;
    configData = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstValid", VW'(valid_out), '0);
    checkOutput("rstEof", VW'(eof_out), '0);
    checkOutput("rstVector", vector_out, '0);
    checkOutput("rstChain", VW'(chainId_out), '0);
    checkOutput("rstOccupancy", VW'(occupancy), '0);
    checkOutput("rstOverflow", VW'(overflow), '0);
    mVec.delete();
    mEof.delete();
    mChain    = 0;
    mChains   = clampModel(INITFW);
    mOverflow = 1'b0;
    mDrops    = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkState();
  endtask

  task automatic randomPhase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randVec(),
                    ($urandom_range(0, 3) != 0), 1'b1, 8'(CFGID), 8'($urandom));
    end
  endtask

  initial begin
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
    applyReset();

    // Single write with one chain: two-edge latency, then empty after the beat.
    v0 = randVec();
    writeVec(v0, 1'b1, 1'b1);
    checkOutput("latEdge0", VW'(valid_out), '0);
    idle(1'b1);
    checkOutput("latEdge1", VW'(valid_out), '0);
    idle(1'b1);
    checkOutput("latEdge2", VW'(valid_out), VW'(1));
    checkOutput("latVector", vector_out, v0);
    checkOutput("latEof", VW'(eof_out), VW'(1));
    checkOutput("latChain", VW'(chainId_out), '0);
    idle(1'b1);
    checkOutput("latEmpty", VW'(empty), VW'(1));
    drainAll(20);

    // Three chains, two vectors back to back: six consecutive beats.
    configure(8'd3);
    v0 = randVec();
    v1 = randVec();
    writeVec(v0, 1'b0, 1'b1);
    writeVec(v1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      checkOutput("replayValid", VW'(valid_out), VW'(1));
    end
    idle(1'b1);
    checkOutput("replayEnd", VW'(valid_out), '0);

    // Backpressure mid-replay: five stalled cycles must freeze the beat.
    writeVec(randVec(), 1'b0, 1'b1);
    writeVec(randVec(), 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    drainAll(40);

    // Fill to full, ignored non-tracing enqueue, then one dropped vector.
    applyReset();
    for (int i = 0; i < DEPTH; i++) writeVec(randVec(), 1'(i[0]), 1'b0);
    checkOutput("fullFlag", VW'(full), VW'(1));
    checkOutput("fullOccupancy", VW'(occupancy), VW'(DEPTH));
    applyStimulus(1'b1, 1'b0, randVec(), 1'b0, 1'b0, 8'h55, 8'h00);
    checkOutput("noTraceNoOverflow", VW'(overflow), '0);
    writeVec(randVec(), 1'b1, 1'b0);
    checkOutput("overflowSet", VW'(overflow), VW'(1));
`ifdef IB_DROP_COUNT_EN
    checkOutput("dropCountOne", VW'(dropCount), VW'(1));
`endif
    drainAll(40);

    // Clamp low (0 -> 1 chain) and high (9 -> 4 chains) with random traffic.
    configure(8'd0);
    randomPhase(60);
    drainAll(100);
    configure(8'd9);
    randomPhase(80);
    drainAll(200);
    configure(8'd2);
    randomPhase(60);
    drainAll(150);

    // Reset with three entries queued, then confirm nothing stale emerges.
    for (int i = 0; i < 3; i++) writeVec(randVec(), 1'b1, 1'b0);
    idle(1'b0);
    applyReset();
    for (int i = 0; i < 5; i++) idle(1'b1);
    checkOutput("postRstValid", VW'(valid_out), '0);
    v0 = randVec();
    writeVec(v0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("postRstVector", vector_out, v0);
    drainAll(20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/input_buffer_mc.md
Name: input_buffer_mc

Overview:
- Next-generation trace input buffer: circular queue of N-lane vectors, IB_DEPTH entries deep, with a per-entry EOF bit stored alongside the data.
- Each queued vector is replayed once per active chain (chainId 0..num_chains-1), with a valid/ready handshake to downstream filter chains.
- Sits between the traced datapath and the vector-scalar reduce / filter stages.
- Adds over the previous generation: backpressure, stored EOF, runtime chain-count configuration, occupancy/overflow reporting, async reset.

Parameters:
- N, 8, vector lanes.
- DATA_WIDTH, 32, bits per lane.
- IB_DEPTH, 4, queue entries; power of two, >=2; all entries usable.
- MAX_CHAINS, 4, maximum chains; power of two, >=2.
- INITIAL_FIRMWARE, 1, reset value of the chain count.
- CONFIG_ID, 0, configId value that addresses this block.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enqueue  in  1  write vector_in/eof_in this cycle.
- eof_in  in  1  end-of-frame tag for the written vector.
- tracing  in  1  1=tracing (enqueue allowed, config frozen); 0=config mode.
- configId  in  8  config target id.
- configData  in  8  config payload (chain count).
- vector_in  in  N x DATA_WIDTH  input vector.
- ready_in  in  1  downstream accepts the current output.
- valid_out  out  1  output beat valid.
- eof_out  out  1  EOF bit of the entry being output.
- vector_out  out  N x DATA_WIDTH  queued vector.
- chainId_out  out  $clog2(MAX_CHAINS)  chain this beat is for.
- full  out  1  occupancy==IB_DEPTH.
- empty  out  1  occupancy==0.
- occupancy  out  $clog2(IB_DEPTH)+1  stored entries.
- overflow  out  1  sticky dropped-enqueue flag.

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, occupancy=0, chainId=0; valid_out=0, eof_out=0, vector_out=0, chainId_out=0, overflow=0; num_chains=clamp(INITIAL_FIRMWARE). Reset mid-operation discards all queued entries.
- Clamp rule: 0 becomes 1; values above MAX_CHAINS become MAX_CHAINS.
- Accept: enqueue & tracing & !full (full taken from the registered occupancy). On accept, {eof_in, vector_in} is written at wr_ptr and wr_ptr increments modulo IB_DEPTH.
- A pop in the same cycle does not free space for a write that cycle.
- Drop: enqueue & tracing & full. Data is discarded and overflow is set to 1; it clears only on reset.
- enqueue with tracing=0 is ignored and does not set overflow.
- Latency: a vector accepted at edge t into an empty queue appears with valid_out=1 after edge t+2. No bypass path.
- Output register: loads the head entry when the register is empty or the current beat is accepted (valid_out & ready_in).
- Hold: while valid_out & !ready_in, vector_out, eof_out, chainId_out and valid_out hold stable.
- Replay: the head entry is issued num_chains times with chainId_out=0,1,...,num_chains-1.
- Pop: rd_ptr advances and occupancy decrements when the beat with chainId_out==num_chains-1 is accepted. eof_out is identical on every replayed beat.
- Occupancy: +1 on accept, -1 on pop, unchanged when both happen in the same cycle. The entry in the output register still counts until popped.
- Config: when tracing=0 & configId==CONFIG_ID, num_chains <= clamp(configData) at the next edge. Writes while tracing=1 are ignored.
- Changing num_chains while entries are queued is illegal (bench must not do it). For robustness, the change takes effect from chainId 0 of the next entry.
- Wrap-around: both pointers wrap from IB_DEPTH-1 to 0; full/empty come from occupancy, not pointer comparison.

Optional Feature:
- IB_DROP_COUNT_EN defined: adds output drop_count [15:0]. It increments on every dropped enqueue, saturates at 16'hFFFF, and resets to 0. overflow is still produced.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single write: num_chains=1, write V0 with eof_in=1 at edge 0, ready_in=1 -> valid_out=1 after edge 2 with vector_out=V0, eof_out=1, chainId_out=0; empty=1 one cycle later.
- Replay: configure num_chains=3 (tracing=0, configId=CONFIG_ID, configData=3), then write V0,V1 -> beats (V0,0),(V0,1),(V0,2),(V1,0),(V1,1),(V1,2) on consecutive cycles.
- Backpressure: ready_in=0 for 5 cycles mid-replay -> outputs frozen, then resume without loss or duplication.
- Full/overflow (IB_DEPTH=4): ready_in=0, write 5 vectors -> full=1, occupancy=4, overflow=1, and the 5th vector never appears; with IB_DROP_COUNT_EN, drop_count=1.
- Wrap and clamp: configData=0 gives 1 chain and configData=9 gives 4 chains; stream 10 vectors with ready_in random -> exact in-order output, pointers wrap cleanly.
- Reset: assert rst_n=0 with 3 entries queued -> all outputs 0 immediately, occupancy=0, and no stale data after release.
